// File: rtl/sprite_renderer.sv
// Bouncing square sprite renderer: two-stage colour pipeline on the pixel enable plus a
// once-per-frame motion FSM. Define SPRITE_BORDER_EN to draw the sprite's outer ring white.
module sprite_renderer #(
    parameter int          H_DISPLAY = 640,
    parameter int          V_DISPLAY = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter int          X0        = 0,
    parameter int          Y0        = 0,
    parameter logic [7:0]  BOX_COLOR = 8'hE0,
    parameter logic [7:0]  BG_COLOR  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkDiv,
    input  logic       hSyncIn,
    input  logic       vSyncIn,
    input  logic [8:0] row,
    input  logic [9:0] column,
    input  logic       displayActive,
    input  logic       run,
    output logic       hSync,
    output logic       vSync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic [1:0] dbgState
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_X = 2'd1,
        MOVE_Y = 2'd2
    } state_t;

    localparam logic [10:0] XL      = 11'(H_DISPLAY - BOX_SIZE);
    localparam logic [10:0] YL      = 11'(V_DISPLAY - BOX_SIZE);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] BOX11   = 11'(BOX_SIZE);
    localparam logic [10:0] BOXM1   = 11'(BOX_SIZE - 1);
    localparam logic        DIR_FWD = 1'b0;
    localparam logic        DIR_REV = 1'b1;

    state_t      state, stateNext;
    logic [10:0] xPos, yPos, xNext, yNext;
    logic        dirX, dirY, dirXNext, dirYNext;
    logic [10:0] col11, row11;
    logic        hitNow, tick, vSyncPrev;
    logic        activeS1, hSyncS1, vSyncS1, hitS1;
    logic [7:0]  pixelNext, colorS2;

    assign col11  = {1'b0, column};
    assign row11  = {2'b00, row};
    assign hitNow = (col11 >= xPos) && (col11 < xPos + BOX11) &&
                    (row11 >= yPos) && (row11 < yPos + BOX11);

`ifdef SPRITE_BORDER_EN
    logic ringNow, ringS1;
    assign ringNow = hitNow && ((col11 == xPos) || (col11 == xPos + BOXM1) ||
                                (row11 == yPos) || (row11 == yPos + BOXM1));
`else
    logic unusedBoxm1;
    assign unusedBoxm1 = ^BOXM1;
`endif

    // Every register in the colour path advances only on cycles where clkDiv is high;
    // with clkDiv low the whole pipeline, including vSyncPrev, holds its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            activeS1  <= 1'b0;
            hSyncS1   <= 1'b1;
            vSyncS1   <= 1'b1;
            hitS1     <= 1'b0;
            vSyncPrev <= 1'b1;
`ifdef SPRITE_BORDER_EN
            ringS1    <= 1'b0;
`endif
        end else if (clkDiv) begin
            activeS1  <= displayActive;
            hSyncS1   <= hSyncIn;
            vSyncS1   <= vSyncIn;
            hitS1     <= hitNow;
            vSyncPrev <= vSyncIn;
`ifdef SPRITE_BORDER_EN
            ringS1    <= ringNow;
`endif
        end
    end

    // Blanking is forced black whatever the background colour.
    always_comb begin
        pixelNext = 8'h00;
        if (activeS1) begin
`ifdef SPRITE_BORDER_EN
            pixelNext = hitS1 ? (ringS1 ? 8'hFF : BOX_COLOR) : BG_COLOR;
`else
            pixelNext = hitS1 ? BOX_COLOR : BG_COLOR;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colorS2 <= 8'h00;
            hSync   <= 1'b1;
            vSync   <= 1'b1;
        end else if (clkDiv) begin
            colorS2 <= pixelNext;
            hSync   <= hSyncS1;
            vSync   <= vSyncS1;
        end
    end

    assign red   = colorS2[7:5];
    assign green = colorS2[4:2];
    assign blue  = colorS2[1:0];

    // Frame tick on the enabled falling edge of the incoming vertical sync.
    assign tick = clkDiv & vSyncPrev & ~vSyncIn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (tick && run) stateNext = MOVE_X;
            MOVE_X:  stateNext = MOVE_Y;
            MOVE_Y:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign dbgState = state;

    always_comb begin
        xNext    = xPos;
        yNext    = yPos;
        dirXNext = dirX;
        dirYNext = dirY;
        if (state == MOVE_X) begin
            if (dirX == DIR_FWD) begin
                if (xPos + STEP11 >= XL) begin
                    xNext    = XL;
                    dirXNext = DIR_REV;
                end else begin
                    xNext = xPos + STEP11;
                end
            end else if (xPos <= STEP11) begin
                xNext    = 11'd0;
                dirXNext = DIR_FWD;
            end else begin
                xNext = xPos - STEP11;
            end
        end
        if (state == MOVE_Y) begin
            if (dirY == DIR_FWD) begin
                if (yPos + STEP11 >= YL) begin
                    yNext    = YL;
                    dirYNext = DIR_REV;
                end else begin
                    yNext = yPos + STEP11;
                end
            end else if (yPos <= STEP11) begin
                yNext    = 11'd0;
                dirYNext = DIR_FWD;
            end else begin
                yNext = yPos - STEP11;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xPos <= 11'(X0);
            yPos <= 11'(Y0);
            dirX <= DIR_FWD;
            dirY <= DIR_FWD;
        end else begin
            xPos <= xNext;
            yPos <= yNext;
            dirX <= dirXNext;
            dirY <= dirYNext;
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: three instances (top-left, near right edge, bottom-right
// corner) share one raster stimulus; a monitor compares each enabled output against exp_q.
module tb_sprite_renderer;

    localparam int W = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkDiv;
    logic       hSyncIn;
    logic       vSyncIn;
    logic [8:0] row;
    logic [9:0] column;
    logic       displayActive;
    logic       run;
    logic       issued;

    wire [2:0]       hsO;
    wire [2:0]       vsO;
    wire [2:0][7:0]  rgbO;
    wire [2:0][1:0]  stO;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int bx[3];
    int by[3];

    always #5 clk = ~clk;

    sprite_renderer dut0 (
        .clk(clk), .rst(rst), .clkDiv(clkDiv), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
        .row(row), .column(column), .displayActive(displayActive), .run(run),
        .hSync(hsO[0]), .vSync(vsO[0]), .red(rgbO[0][7:5]), .green(rgbO[0][4:2]),
        .blue(rgbO[0][1:0]), .dbgState(stO[0])
    );

    sprite_renderer #(.X0(606)) dut1 (
        .clk(clk), .rst(rst), .clkDiv(clkDiv), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
        .row(row), .column(column), .displayActive(displayActive), .run(run),
        .hSync(hsO[1]), .vSync(vsO[1]), .red(rgbO[1][7:5]), .green(rgbO[1][4:2]),
        .blue(rgbO[1][1:0]), .dbgState(stO[1])
    );

    sprite_renderer #(.X0(608), .Y0(448)) dut2 (
        .clk(clk), .rst(rst), .clkDiv(clkDiv), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
        .row(row), .column(column), .displayActive(displayActive), .run(run),
        .hSync(hsO[2]), .vSync(vsO[2]), .red(rgbO[2][7:5]), .green(rgbO[2][4:2]),
        .blue(rgbO[2][1:0]), .dbgState(stO[2])
    );

    function automatic logic [7:0] expPix(input int c, input int r, input logic act,
                                          input int x, input int y);
        logic hit;
        if (!act) return 8'h00;
        hit = (c >= x) && (c < x + 32) && (r >= y) && (r < y + 32);
        if (!hit) return 8'h00;
`ifdef SPRITE_BORDER_EN
        if (c == x || c == x + 31 || r == y || r == y + 31) return 8'hFF;
`endif
        return 8'hE0;
    endfunction

    // Monitor: tracks the two-enable latency with its own token pipe and pops one entry per token.
    initial begin : monitor
        logic [1:0]   tok;
        logic [W-1:0] e;
        logic [9:0]   got;
        tok = 2'b00;
        forever begin
            @(posedge clk);
            if (rst) begin
                tok = 2'b00;
            end else if (clkDiv) begin
                tok = {tok[0], issued};
                #1;
                if (tok[1]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pipe_out: output token got with empty expected queue");
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < 3; i++) begin
                            got = {hsO[i], vsO[i], rgbO[i]};
                            checks++;
                            if (got !== e[i*10 +: 10]) begin
                                errors++;
                                $display("FAIL pix_inst%0d: got {hs,vs,rgb}=%h expected %h (t=%0t)",
                                         i, got, e[i*10 +: 10], $time);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic drivePixel(input int r, input int c, input logic act, input logic hs,
                              input logic vs, input int gap);
        logic [W-1:0] e;
        @(negedge clk);
        row           = 9'(r);
        column        = 10'(c);
        displayActive = act;
        hSyncIn       = hs;
        vSyncIn       = vs;
        clkDiv        = 1'b1;
        issued        = 1'b1;
        for (int i = 0; i < 3; i++) e[i*10 +: 10] = {hs, vs, expPix(c, r, act, bx[i], by[i])};
        exp_q.push_back(e);
        @(posedge clk);
        repeat (gap) begin
            @(negedge clk);
            clkDiv        = 1'b0;
            issued        = 1'b0;
            row           = 9'($urandom_range(0, 479));
            column        = 10'($urandom_range(0, 639));
            displayActive = 1'($urandom_range(0, 1));
            hSyncIn       = 1'($urandom_range(0, 1));
            vSyncIn       = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic flush();
        repeat (3) begin
            @(negedge clk);
            clkDiv        = 1'b1;
            issued        = 1'b0;
            displayActive = 1'b0;
            hSyncIn       = 1'b1;
            vSyncIn       = 1'b1;
            @(posedge clk);
        end
    endtask

    task automatic checkState(input logic [1:0] exp, input string name);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stO[i] !== exp) begin
                errors++;
                $display("FAIL %s_inst%0d: state got %0d expected %0d", name, i, stO[i], exp);
            end
        end
    endtask

    task automatic checkOut(input int i, input logic [9:0] exp, input string name);
        checks++;
        if ({hsO[i], vsO[i], rgbO[i]} !== exp) begin
            errors++;
            $display("FAIL %s_inst%0d: got {hs,vs,rgb}=%h expected %h", name, i,
                     {hsO[i], vsO[i], rgbO[i]}, exp);
        end
    endtask

    task automatic doTick(input logic runVal);
        #1 run = runVal;
        drivePixel(490, 0, 1'b0, 1'b1, 1'b0, 0);
        #1 checkState(runVal ? 2'd1 : 2'd0, "st_tick");
        drivePixel(491, 0, 1'b0, 1'b0, 1'b0, 0);
        #1 checkState(runVal ? 2'd2 : 2'd0, "st_movex");
        drivePixel(492, 0, 1'b0, 1'b1, 1'b0, 0);
        #1 checkState(2'd0, "st_movey");
        drivePixel(493, 0, 1'b0, 1'b1, 1'b1, 0);
        drivePixel(494, 0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic probe(input int x, input int y);
        drivePixel(y, x, 1'b1, 1'b1, 1'b1, 0);
        if (x > 0) drivePixel(y, x - 1, 1'b1, 1'b0, 1'b1, 0);
        drivePixel(y, x + 31, 1'b1, 1'b1, 1'b1, 0);
        drivePixel(y, x + 32, 1'b1, 1'b0, 1'b1, 0);
        if (y > 0) drivePixel(y - 1, x, 1'b1, 1'b1, 1'b1, 0);
        drivePixel(y + 31, x, 1'b1, 1'b1, 1'b1, 0);
        drivePixel(y + 32, x, 1'b1, 1'b0, 1'b1, 0);
        drivePixel(y + 1, x + 1, 1'b1, 1'b1, 1'b1, 0);
    endtask

    task automatic probeAll();
        for (int i = 0; i < 3; i++) probe(bx[i], by[i]);
        flush();
    endtask

    // Directed raster vectors: {row, column, active, hSync}.
    int pr[13] = '{0, 0, 0, 5, 31, 32, 0, 0, 0, 0, 448, 479, 447};
    int pc[13] = '{0, 32, 31, 10, 31, 0, 606, 605, 637, 638, 608, 639, 608};
    logic pa[13] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    logic ph[13] = '{1, 0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};

    initial begin : driver
        rst = 1'b1; clkDiv = 1'b0; hSyncIn = 1'b1; vSyncIn = 1'b1; row = '0; column = '0;
        displayActive = 1'b0; run = 1'b0; issued = 1'b0;
        bx = '{0, 606, 608};
        by = '{0, 0, 448};
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) checkOut(i, 10'h300, "reset");
        checkState(2'd0, "st_reset");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 13; k++) drivePixel(pr[k], pc[k], pa[k], ph[k], 1'b1, 0);
        flush();

        // Pixel enable low for two cycles between pixels, with random inputs that must be ignored.
        drivePixel(10, 10, 1'b1, 1'b0, 1'b1, 2);
        drivePixel(10, 40, 1'b1, 1'b1, 1'b1, 2);
        drivePixel(0, 620, 1'b1, 1'b0, 1'b1, 3);
        drivePixel(460, 620, 1'b1, 1'b1, 1'b1, 2);
        drivePixel(1, 1, 1'b1, 1'b1, 1'b1, 1);
        flush();

        doTick(1'b1);
        bx = '{2, 608, 608};
        by = '{2, 2, 448};
        probeAll();

        doTick(1'b1);
        bx = '{4, 606, 606};
        by = '{4, 4, 446};
        probeAll();

        repeat (3) doTick(1'b1);
        bx = '{10, 600, 600};
        by = '{10, 10, 440};
        probeAll();

        repeat (3) doTick(1'b0);
        probeAll();

        // Load a sprite pixel into the pipe without a token, then reset asynchronously mid-cycle.
        @(negedge clk);
        row = 9'd12; column = 10'd12; displayActive = 1'b1; hSyncIn = 1'b0; vSyncIn = 1'b1;
        clkDiv = 1'b1; issued = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkOut(0, 10'h1E0, "pre_reset");
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) checkOut(i, 10'h300, "async_reset");
        checkState(2'd0, "st_async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bx = '{0, 606, 608};
        by = '{0, 0, 448};
        flush();
        doTick(1'b1);
        bx = '{2, 608, 608};
        by = '{2, 2, 448};
        probeAll();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
